// File: rtl/cache_tag_lookup.sv
// Tag-store lookup stage: latches a request, compares its tag against every way of the set,
// picks hit/victim, updates valid/tag/LRU state and returns one registered response.
// Optional macro LOOKUP_STATS_EN adds hit_count/miss_count outputs and a per-response trace.
module cache_tag_lookup #(
    parameter int addressSize = 32,
    parameter int tagBits     = 12,
    parameter int indexBits   = 14,
    parameter int offsetBits  = 6,
    parameter int ways        = 8,
    localparam int wayBits    = $clog2(ways)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [addressSize-1:0] req_address,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [wayBits-1:0]     resp_way,
    output logic [tagBits-1:0]     resp_tag,
    output logic [indexBits-1:0]   resp_index,
    output logic                   resp_victim_valid,
    output logic [tagBits-1:0]     resp_victim_tag
`ifdef LOOKUP_STATS_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);

    localparam int sets = 1 << indexBits;
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_PEEK   = 2'b11;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COMPARE = 2'd1, ST_RESPOND = 2'd2} state_e;

    // Reset value of a set's LRU counters: way k holds k.
    function automatic logic [ways*wayBits-1:0] lru_init();
        logic [ways*wayBits-1:0] v;
        for (int w = 0; w < ways; w++) begin
            v[w*wayBits +: wayBits] = wayBits'(w);
        end
        return v;
    endfunction

    state_e state_q, state_d;

    // Set images are only trusted once written; set_init_q gives a one-cycle reset of the whole store.
    logic [sets-1:0]             set_init_q;
    logic [ways-1:0]             valid_q [sets];
    logic [ways*tagBits-1:0]     tags_q  [sets];
    logic [ways*wayBits-1:0]     lru_q   [sets];

    logic [1:0]                  op_q;
    logic [tagBits-1:0]          req_tag_q;
    logic [indexBits-1:0]        req_idx_q;

    logic [ways-1:0]             set_valid_s;
    logic [ways*tagBits-1:0]     set_tags_s;
    logic [ways*wayBits-1:0]     set_lru_s;
    logic                        hit_s, has_inv_s;
    logic [wayBits-1:0]          hit_way_s, inv_way_s, old_way_s, victim_s, touch_way_s;
    logic [wayBits-1:0]          touch_cnt_s;
    logic [ways*wayBits-1:0]     lru_touched_s;

    logic                        hit_d, hit_q;
    logic [wayBits-1:0]          way_d, way_q;
    logic                        vic_valid_d, vic_valid_q;
    logic [tagBits-1:0]          vic_tag_d, vic_tag_q;
    logic                        wr_d, wr_q;
    logic [ways-1:0]             valid_new_d, valid_new_q;
    logic [ways*tagBits-1:0]     tags_new_d, tags_new_q;
    logic [ways*wayBits-1:0]     lru_new_d, lru_new_q;

    logic                        resp_valid_q, resp_hit_q, resp_vv_q;
    logic [wayBits-1:0]          resp_way_q;
    logic [tagBits-1:0]          resp_tag_q, resp_vt_q;
    logic [indexBits-1:0]        resp_index_q;

    logic                        unused_offset_s;
    assign unused_offset_s = ^req_address[offsetBits-1:0];

    assign req_ready         = (state_q == ST_IDLE);
    assign resp_valid        = resp_valid_q;
    assign resp_hit          = resp_hit_q;
    assign resp_way          = resp_way_q;
    assign resp_tag          = resp_tag_q;
    assign resp_index        = resp_index_q;
    assign resp_victim_valid = resp_vv_q;
    assign resp_victim_tag   = resp_vt_q;

    // Next-state logic for the IDLE -> COMPARE -> RESPOND sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    state_d = req_valid ? ST_COMPARE : ST_IDLE;
            ST_COMPARE: state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Set read, hit/victim resolution and LRU touch
    always_comb begin
        set_valid_s = set_init_q[req_idx_q] ? valid_q[req_idx_q] : '0;
        set_tags_s  = set_init_q[req_idx_q] ? tags_q[req_idx_q]  : '0;
        set_lru_s   = set_init_q[req_idx_q] ? lru_q[req_idx_q]   : lru_init();
        hit_s       = 1'b0;
        hit_way_s   = '0;
        has_inv_s   = 1'b0;
        inv_way_s   = '0;
        old_way_s   = '0;
        // Descending scans so the lowest-numbered qualifying way wins.
        for (int w = ways - 1; w >= 0; w--) begin
            hit_s     = (set_valid_s[w] && set_tags_s[w*tagBits +: tagBits] == req_tag_q) ? 1'b1 : hit_s;
            hit_way_s = (set_valid_s[w] && set_tags_s[w*tagBits +: tagBits] == req_tag_q) ? wayBits'(w) : hit_way_s;
            has_inv_s = !set_valid_s[w] ? 1'b1 : has_inv_s;
            inv_way_s = !set_valid_s[w] ? wayBits'(w) : inv_way_s;
            old_way_s = (set_lru_s[w*wayBits +: wayBits] == wayBits'(ways - 1)) ? wayBits'(w) : old_way_s;
        end
        victim_s    = has_inv_s ? inv_way_s : old_way_s;
        touch_way_s = hit_s ? hit_way_s : victim_s;
        touch_cnt_s = set_lru_s[touch_way_s*wayBits +: wayBits];
        for (int w = 0; w < ways; w++) begin
            lru_touched_s[w*wayBits +: wayBits] = (set_lru_s[w*wayBits +: wayBits] < touch_cnt_s)
                ? set_lru_s[w*wayBits +: wayBits] + wayBits'(1) : set_lru_s[w*wayBits +: wayBits];
        end
        lru_touched_s[touch_way_s*wayBits +: wayBits] = '0;
    end

    // Per-op response fields and next set image
    always_comb begin
        hit_d       = hit_s;
        way_d       = touch_way_s;
        vic_valid_d = hit_s ? 1'b0 : set_valid_s[victim_s];
        vic_tag_d   = hit_s ? '0 : set_tags_s[victim_s*tagBits +: tagBits];
        wr_d        = 1'b0;
        valid_new_d = set_valid_s;
        tags_new_d  = set_tags_s;
        lru_new_d   = set_lru_s;
        case (op_q)
            OP_LOOKUP: begin
                wr_d      = hit_s;
                lru_new_d = hit_s ? lru_touched_s : set_lru_s;
            end
            OP_FILL: begin
                wr_d      = 1'b1;
                lru_new_d = lru_touched_s;
                if (hit_s) begin
                    valid_new_d = set_valid_s;
                end else begin
                    valid_new_d[victim_s]                    = 1'b1;
                    tags_new_d[victim_s*tagBits +: tagBits]  = req_tag_q;
                end
            end
            OP_INVAL: begin
                wr_d = hit_s;
                if (hit_s) begin
                    valid_new_d[hit_way_s] = 1'b0;
                end else begin
                    valid_new_d = set_valid_s;
                end
            end
            OP_PEEK: wr_d = 1'b0;
            default: wr_d = 1'b0;
        endcase
    end

    // FSM, request latch, compare-stage results and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= 2'b00;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            vic_valid_q  <= 1'b0;
            vic_tag_q    <= '0;
            wr_q         <= 1'b0;
            valid_new_q  <= '0;
            tags_new_q   <= '0;
            lru_new_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
            resp_tag_q   <= '0;
            resp_index_q <= '0;
            resp_vv_q    <= 1'b0;
            resp_vt_q    <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_q == ST_RESPOND);
            if (req_valid && req_ready) begin
                op_q      <= req_op;
                req_tag_q <= req_address[addressSize-1 -: tagBits];
                req_idx_q <= req_address[addressSize-tagBits-1 -: indexBits];
            end
            if (state_q == ST_COMPARE) begin
                hit_q       <= hit_d;
                way_q       <= way_d;
                vic_valid_q <= vic_valid_d;
                vic_tag_q   <= vic_tag_d;
                wr_q        <= wr_d;
                valid_new_q <= valid_new_d;
                tags_new_q  <= tags_new_d;
                lru_new_q   <= lru_new_d;
            end
            if (state_q == ST_RESPOND) begin
                resp_hit_q   <= hit_q;
                resp_way_q   <= way_q;
                resp_tag_q   <= req_tag_q;
                resp_index_q <= req_idx_q;
                resp_vv_q    <= vic_valid_q;
                resp_vt_q    <= vic_tag_q;
            end
        end
    end

    // Set-initialised flags; cleared together so reset invalidates every line at once
    always_ff @(posedge clk) begin
        if (reset) begin
            set_init_q <= '0;
        end else if (state_q == ST_RESPOND && wr_q) begin
            set_init_q[req_idx_q] <= 1'b1;
        end
    end

    // Tag store commit in RESPOND; no reset needed because set_init_q masks stale contents
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_RESPOND && wr_q) begin
            valid_q[req_idx_q] <= valid_new_q;
            tags_q[req_idx_q]  <= tags_new_q;
            lru_q[req_idx_q]   <= lru_new_q;
        end
    end

`ifdef LOOKUP_STATS_EN
    // Hit/miss statistics for LOOKUP and FILL, plus a per-response trace
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state_q == ST_RESPOND) begin
            if (op_q == OP_LOOKUP || op_q == OP_FILL) begin
                hit_count  <= hit_count + {31'd0, hit_q};
                miss_count <= miss_count + {31'd0, !hit_q};
            end else begin
                hit_count  <= hit_count;
            end
            $display("cache_tag_lookup: op=%0d tag=0x%0h index=0x%0h hit=%0b way=%0d",
                     op_q, req_tag_q, req_idx_q, hit_q, way_q);
        end else begin
            hit_count <= hit_count;
        end
    end
`endif

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Scoreboard bench for cache_tag_lookup: a behavioural cache model predicts each response
// when the request is driven; the monitor pops and compares when resp_valid pulses.
module tb_cache_tag_lookup;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_address;
    logic        resp_valid, resp_hit, resp_victim_valid;
    logic [2:0]  resp_way;
    logic [11:0] resp_tag, resp_victim_tag;
    logic [13:0] resp_index;
`ifdef LOOKUP_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_tag_lookup dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_address(req_address), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_way(resp_way), .resp_tag(resp_tag),
        .resp_index(resp_index), .resp_victim_valid(resp_victim_valid),
        .resp_victim_tag(resp_victim_tag)
`ifdef LOOKUP_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        hit;
        logic [2:0]  way;
        logic [11:0] tag;
        logic [13:0] idx;
        logic        vv;
        logic [11:0] vt;
        int          acc;
    } exp_t;

    exp_t sb[$];

    // Behavioural cache model, keyed by set index.
    logic [7:0]  m_valid [int];
    logic [95:0] m_tags  [int];
    logic [23:0] m_lru   [int];
    int m_hits = 0;
    int m_misses = 0;

    task automatic model_clear();
        m_valid.delete();
        m_tags.delete();
        m_lru.delete();
        m_hits = 0;
        m_misses = 0;
        sb.delete();
    endtask

    task automatic model_op(input logic [1:0] op, input logic [31:0] addr, output exp_t e);
        logic [7:0]  v;
        logic [95:0] t;
        logic [23:0] l;
        int c[8];
        int key, hw, vw, tw, tc;
        logic [11:0] tg;
        tg = addr[31:20];
        key = int'(addr[19:6]);
        if (m_valid.exists(key)) begin
            v = m_valid[key];
            t = m_tags[key];
            for (int k = 0; k < 8; k++) c[k] = int'(m_lru[key][k*3 +: 3]);
        end else begin
            v = 8'h00;
            t = '0;
            for (int k = 0; k < 8; k++) c[k] = k;
        end
        hw = -1;
        vw = -1;
        for (int k = 0; k < 8; k++) if (hw < 0 && v[k] && t[k*12 +: 12] == tg) hw = k;
        for (int k = 0; k < 8; k++) if (vw < 0 && !v[k]) vw = k;
        if (vw < 0) for (int k = 0; k < 8; k++) if (c[k] == 7) vw = k;
        e.tag = tg;
        e.idx = addr[19:6];
        e.acc = 0;
        if (hw >= 0) begin
            e.hit = 1'b1; e.way = 3'(hw); e.vv = 1'b0; e.vt = 12'h000;
        end else begin
            e.hit = 1'b0; e.way = 3'(vw); e.vv = v[vw]; e.vt = t[vw*12 +: 12];
        end
        tw = -1;
        case (op)
            2'b00: if (hw >= 0) tw = hw;
            2'b01: begin
                if (hw >= 0) tw = hw;
                else begin
                    v[vw] = 1'b1;
                    t[vw*12 +: 12] = tg;
                    tw = vw;
                end
            end
            2'b10: if (hw >= 0) v[hw] = 1'b0;
            default: ;
        endcase
        if (tw >= 0) begin
            tc = c[tw];
            for (int k = 0; k < 8; k++) if (c[k] < tc) c[k]++;
            c[tw] = 0;
        end
        if (op == 2'b00 || op == 2'b01) begin
            if (hw >= 0) m_hits++;
            else m_misses++;
        end
        for (int k = 0; k < 8; k++) l[k*3 +: 3] = 3'(c[k]);
        m_valid[key] = v;
        m_tags[key] = t;
        m_lru[key] = l;
    endtask

    exp_t        mon_e;
    logic        last_hit, last_vv;
    logic [2:0]  last_way;
    logic [11:0] last_vt;

    // Response monitor: sampled on the falling edge
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_hit", resp_hit, mon_e.hit);
                check("resp_way", resp_way, mon_e.way);
                check("resp_tag", resp_tag, mon_e.tag);
                check("resp_index", resp_index, mon_e.idx);
                check("resp_victim_valid", resp_victim_valid, mon_e.vv);
                if (mon_e.hit || mon_e.vv) check("resp_victim_tag", resp_victim_tag, mon_e.vt);
                check("latency", cyc - mon_e.acc, 32'd2);
            end
            last_hit = resp_hit;
            last_way = resp_way;
            last_vv  = resp_victim_valid;
            last_vt  = resp_victim_tag;
        end
    end

    function automatic logic [31:0] mk(input logic [11:0] tag, input logic [13:0] idx);
        logic [5:0] off;
        off = 6'($urandom);
        return {tag, idx, off};
    endfunction

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    // Called just after a falling edge with the DUT idle.
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr);
        exp_t e;
        check("req_ready_idle", req_ready, 32'd1);
        model_op(op, addr, e);
        e.acc = cyc + 1;
        sb.push_back(e);
        req_valid = 1'b1;
        req_op = op;
        req_address = addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_address = $urandom;
        wait_idle("resp");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [31:0] a;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_address = 32'h0;
        do_reset();
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_resp_hit", resp_hit, 32'd0);
        check("rst_resp_way", resp_way, 32'd0);
        check("rst_resp_tag", resp_tag, 32'd0);
        check("rst_resp_index", resp_index, 32'd0);
        check("rst_victim", {resp_victim_valid, resp_victim_tag}, 32'd0);
        check("rst_req_ready", req_ready, 32'd1);

        // Basic lookup / fill / lookup.
        do_req(2'b00, 32'h12345678);
        check("plan_lookup_miss", {last_hit, last_way, last_vv}, {27'd0, 1'b0, 3'd0, 1'b0});
        do_req(2'b01, 32'h12345678);
        check("plan_fill_way0", {last_hit, last_way}, {28'd0, 1'b0, 3'd0});
        do_req(2'b00, 32'h12345678);
        check("plan_lookup_hit", {last_hit, last_way}, {28'd0, 1'b1, 3'd0});

        // Eviction order in set 0x1159.
        do_reset();
        for (int k = 0; k < 8; k++) do_req(2'b01, mk(12'(k), 14'h1159));
        do_req(2'b01, mk(12'h008, 14'h1159));
        check("plan_evict_way0", {last_way, last_vv, last_vt}, {16'd0, 3'd0, 1'b1, 12'h000});
        do_req(2'b00, mk(12'h001, 14'h1159));
        check("plan_lookup_way1", {last_hit, last_way}, {28'd0, 1'b1, 3'd1});
        do_req(2'b01, mk(12'h009, 14'h1159));
        check("plan_evict_way2", {last_way, last_vt}, {17'd0, 3'd2, 12'h002});

        // Invalidate, then peeks must not disturb the next victim.
        do_req(2'b10, mk(12'h003, 14'h1159));
        check("plan_inval_hit", {last_hit, last_way}, {28'd0, 1'b1, 3'd3});
        do_req(2'b00, mk(12'h003, 14'h1159));
        check("plan_after_inval", {last_hit, last_way, last_vv}, {27'd0, 1'b0, 3'd3, 1'b0});
        do_req(2'b11, mk(12'h555, 14'h1159));
        do_req(2'b01, mk(12'h777, 14'h1159));
        check("plan_fill_invalid_way", last_way, 32'd3);
        do_req(2'b11, mk(12'h004, 14'h1159));
        do_req(2'b01, mk(12'hABC, 14'h1159));
        check("plan_peek_no_touch", {last_way, last_vt}, {17'd0, 3'd4, 12'h004});

        // Reset while a FILL is in COMPARE.
        req_valid = 1'b1;
        req_op = 2'b01;
        req_address = mk(12'h0AA, 14'h0022);
        a = req_address;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("rst_abort_no_resp", resp_valid, 32'd0);
            check("rst_abort_ready", req_ready, 32'd1);
        end
        do_req(2'b00, a);
        check("plan_aborted_fill_miss", last_hit, 32'd0);

        // Busy handling: request held for 10 cycles with a changing address.
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_op = (i % 2 == 0) ? 2'b01 : 2'b00;
            req_address = mk(12'(12'h040 + i), 14'(14'h0100 + i % 2));
            check("busy_ready", req_ready, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 0) begin
                model_op(req_op, req_address, e);
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_idle("busy");

        // Mixed traffic on the boundary sets.
        for (int i = 0; i < 40; i++) begin
            do_req(2'($urandom_range(0, 3)),
                   mk(12'($urandom_range(0, 11)), ($urandom_range(0, 1) == 0) ? 14'h0000 : 14'h3FFF));
        end

`ifdef LOOKUP_STATS_EN
        do_reset();
        do_req(2'b00, mk(12'h011, 14'h0005));
        do_req(2'b01, mk(12'h011, 14'h0005));
        do_req(2'b00, mk(12'h011, 14'h0005));
        do_req(2'b01, mk(12'h011, 14'h0005));
        do_req(2'b11, mk(12'h011, 14'h0005));
        do_req(2'b10, mk(12'h022, 14'h0005));
        do_req(2'b00, mk(12'h033, 14'h0005));
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("plan_hit_count", hit_count, 32'd2);
        check("plan_miss_count", miss_count, 32'd3);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
